// File: rtl/gray_sobel_bist_pkg.sv
// Shared types and defaults for the gray/sobel BIST run sequencer.
package gray_sobel_bist_pkg;

    localparam int PX_W_DEF          = 24;
    localparam int SIG_W_DEF         = 24;
    localparam int CNT_W_DEF         = 16;
    localparam int DRAIN_TIMEOUT_DEF = 64;

    // Run phases; the encoding doubles as the debug view of the sequencer.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SEED    = 3'd2,
        ST_RUN     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_DONE    = 3'd6
    } bist_state_e;

    // Single-bit control outputs, all purely a function of the phase.
    typedef struct packed {
        logic lfsr_cfg;
        logic lfsr_cfg_rdy;
        logic lfsr_en;
        logic sa_en;
        logic sa_clear;
        logic busy;
        logic done;
    } bist_ctrl_t;

    function automatic bist_ctrl_t ctrl_for_state(input bist_state_e s);
        bist_ctrl_t c;
        c              = '0;
        c.sa_clear     = (s == ST_CLEAR);
        c.lfsr_cfg     = (s == ST_SEED);
        c.lfsr_cfg_rdy = (s == ST_SEED);
        c.lfsr_en      = (s == ST_RUN);
        c.sa_en        = (s == ST_RUN) || (s == ST_DRAIN);
        c.busy         = (s != ST_IDLE) && (s != ST_DONE);
        c.done         = (s == ST_DONE);
        return c;
    endfunction

endpackage

// File: rtl/bist_event_counter.sv
// Saturating event counter: counts inc pulses up to limit; hit flags that the
// count reaches the limit at the coming clock edge.
module bist_event_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clear_i,
    input  logic         inc_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         hit_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment until the limit is reached.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q < limit_i)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign hit_o   = (count_d == limit_i);

endmodule

// File: rtl/gray_sobel_bist_sequencer.sv
// Autonomous BIST run controller: clears the SA, seeds the LFSR, streams a
// fixed number of pixels, waits for the pipeline to drain, then captures and
// judges the signature.
module gray_sobel_bist_sequencer
    import gray_sobel_bist_pkg::*;
#(
    parameter int PX_W          = PX_W_DEF,
    parameter int SIG_W         = SIG_W_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] frame_len_i,
    input  logic [PX_W-1:0]  seed_i,
    input  logic [SIG_W-1:0] golden_i,
    output logic             lfsr_cfg_o,
    output logic             lfsr_cfg_rdy_o,
    output logic [PX_W-1:0]  lfsr_cfg_data_o,
    output logic             lfsr_en_o,
    input  logic             lfsr_rdy_i,
    input  logic             px_rdy_i,
    output logic             sa_en_o,
    output logic             sa_clear_o,
    input  logic [SIG_W-1:0] sa_signature_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [SIG_W-1:0] signature_o
);

    localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

    bist_state_e      state_q, state_d;
    bist_ctrl_t       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] frame_len_q, frame_len_d;
    logic [PX_W-1:0]  seed_q, seed_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             error_q, error_d;

    logic in_run;
    logic in_stream;
    logic in_drain;

    assign in_run    = (state_q == ST_RUN);
    assign in_drain  = (state_q == ST_DRAIN);
    assign in_stream = in_run || in_drain;

    // Index 0 counts pixels issued by the LFSR, index 1 pixels received
    // from the pipeline. Both share the latched frame length as their limit.
    logic [1:0]             frame_clear;
    logic [1:0]             frame_inc;
    logic [1:0]             frame_hit;
    logic [1:0][CNT_W-1:0]  frame_count;

    assign frame_clear[0] = abort_i || !in_run;
    assign frame_inc[0]   = lfsr_rdy_i && in_run;
    assign frame_clear[1] = abort_i || !in_stream;
    assign frame_inc[1]   = px_rdy_i && in_stream;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_frame_cnt
            bist_event_counter #(
                .W (CNT_W)
            ) u_cnt (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .clear_i (frame_clear[gi]),
                .inc_i   (frame_inc[gi]),
                .limit_i (frame_len_q),
                .count_o (frame_count[gi]),
                .hit_o   (frame_hit[gi])
            );
        end
    endgenerate

    // Idle-cycle watchdog for DRAIN; any received pixel restarts it.
    logic              idle_hit;
    logic [IDLE_W-1:0] idle_count;

    bist_event_counter #(
        .W (IDLE_W)
    ) u_idle_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (abort_i || !in_drain || px_rdy_i),
        .inc_i   (in_drain),
        .limit_i (IDLE_W'(DRAIN_TIMEOUT)),
        .count_o (idle_count),
        .hit_o   (idle_hit)
    );

    logic unused_counts;
    assign unused_counts = ^{frame_count[0], idle_count};

    // A pixel arriving after the full frame was already received.
    logic overrun;
    assign overrun = px_rdy_i && (frame_count[1] == frame_len_q);

    // Next-state, latches and result capture; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        seed_d      = seed_q;
        golden_d    = golden_q;
        sig_d       = sig_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        error_d     = error_q;

        if (abort_i) begin
            state_d     = ST_IDLE;
            frame_len_d = '0;
            seed_d      = '0;
            golden_d    = '0;
            sig_d       = '0;
            pass_d      = 1'b0;
            timeout_d   = 1'b0;
            error_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        frame_len_d = frame_len_i;
                        seed_d      = seed_i;
                        golden_d    = golden_i;
                        pass_d      = 1'b0;
                        timeout_d   = 1'b0;
                        error_d     = 1'b0;
                        state_d     = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // An empty frame just captures the freshly cleared SA.
                    state_d = (frame_len_q == '0) ? ST_CAPTURE : ST_SEED;
                end
                ST_SEED: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (overrun) begin
                        error_d = 1'b1;
                    end
                    if (frame_hit[0]) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (overrun) begin
                        error_d = 1'b1;
                    end
                    // Leave on the edge that delivers the last pixel, so the
                    // SA holds it by the time CAPTURE samples the signature.
                    if (frame_hit[1]) begin
                        state_d = ST_CAPTURE;
                    end else if (idle_hit) begin
                        timeout_d = 1'b1;
                        state_d   = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    sig_d   = sa_signature_i;
                    pass_d  = (sa_signature_i == golden_q) && !timeout_q && !error_q;
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        ctrl_d = ctrl_for_state(state_d);
    end

    // State, latched run parameters, results and registered control outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= '0;
            frame_len_q <= '0;
            seed_q      <= '0;
            golden_q    <= '0;
            sig_q       <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            frame_len_q <= frame_len_d;
            seed_q      <= seed_d;
            golden_q    <= golden_d;
            sig_q       <= sig_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            error_q     <= error_d;
        end
    end

    assign lfsr_cfg_o      = ctrl_q.lfsr_cfg;
    assign lfsr_cfg_rdy_o  = ctrl_q.lfsr_cfg_rdy;
    assign lfsr_cfg_data_o = seed_q;
    assign lfsr_en_o       = ctrl_q.lfsr_en;
    assign sa_en_o         = ctrl_q.sa_en;
    assign sa_clear_o      = ctrl_q.sa_clear;
    assign busy_o          = ctrl_q.busy;
    assign done_o          = ctrl_q.done;
    assign pass_o          = pass_q;
    assign timeout_o       = timeout_q;
    assign signature_o     = sig_q;

endmodule

// File: tb/tb_gray_sobel_bist_sequencer.sv
// Scoreboard bench: an LFSR / 5-stage pipeline / MISR environment surrounds the
// sequencer; each run's expected result comes from a direct frame computation.
module tb_gray_sobel_bist_sequencer;
    import gray_sobel_bist_pkg::*;

    localparam int PX_W  = PX_W_DEF;
    localparam int SIG_W = SIG_W_DEF;
    localparam int CNT_W = CNT_W_DEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_i, start_i, abort_i;
    logic [CNT_W-1:0] frame_len_i;
    logic [PX_W-1:0]  seed_i;
    logic [SIG_W-1:0] golden_i;
    logic             lfsr_cfg_o, lfsr_cfg_rdy_o, lfsr_en_o, lfsr_rdy_i, px_rdy_i;
    logic [PX_W-1:0]  lfsr_cfg_data_o;
    logic             sa_en_o, sa_clear_o, busy_o, done_o, pass_o, timeout_o;
    logic [SIG_W-1:0] sa_signature_i, signature_o;

    gray_sobel_bist_sequencer dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .frame_len_i     (frame_len_i),
        .seed_i          (seed_i),
        .golden_i        (golden_i),
        .lfsr_cfg_o      (lfsr_cfg_o),
        .lfsr_cfg_rdy_o  (lfsr_cfg_rdy_o),
        .lfsr_cfg_data_o (lfsr_cfg_data_o),
        .lfsr_en_o       (lfsr_en_o),
        .lfsr_rdy_i      (lfsr_rdy_i),
        .px_rdy_i        (px_rdy_i),
        .sa_en_o         (sa_en_o),
        .sa_clear_o      (sa_clear_o),
        .sa_signature_i  (sa_signature_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .timeout_o       (timeout_o),
        .signature_o     (signature_o)
    );

    function automatic logic [PX_W-1:0] lfsr_step(input logic [PX_W-1:0] s);
        return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
    endfunction

    function automatic logic [PX_W-1:0] pix_func(input logic [PX_W-1:0] p);
        return p ^ {p[11:0], p[23:12]};
    endfunction

    function automatic logic [SIG_W-1:0] misr(input logic [SIG_W-1:0] s, input logic [PX_W-1:0] x);
        return {s[22:0], s[23] ^ s[20]} ^ x;
    endfunction

    // Signature of a whole frame: every pixel except an optionally lost one.
    function automatic logic [SIG_W-1:0] ref_signature(input logic [PX_W-1:0] seed, input int n, input int drop);
        logic [PX_W-1:0]  s   = seed;
        logic [SIG_W-1:0] sig = '0;
        for (int i = 0; i < n; i++) begin
            if (i != drop) sig = misr(sig, pix_func(s));
            s = lfsr_step(s);
        end
        return sig;
    endfunction

    // Environment: LFSR, 5-cycle pipeline (with optional pixel loss), SA.
    logic [PX_W-1:0]  lfsr_state = '0;
    logic [4:0]       vld_dly = '0;
    logic [PX_W-1:0]  dat_dly [5];
    logic [SIG_W-1:0] sa_sig = '0;
    int               in_idx = 0;
    int               drop_idx = -1;

    assign lfsr_rdy_i     = lfsr_en_o;
    assign px_rdy_i       = vld_dly[4];
    assign sa_signature_i = sa_sig;

    always @(posedge clk) begin
        if (lfsr_cfg_rdy_o) lfsr_state <= lfsr_cfg_data_o;
        else if (lfsr_en_o) lfsr_state <= lfsr_step(lfsr_state);
        if (sa_clear_o) in_idx <= 0;
        else if (lfsr_rdy_i) in_idx <= in_idx + 1;
        if (reset_i) vld_dly <= '0;
        else vld_dly <= {vld_dly[3:0], lfsr_rdy_i && (in_idx != drop_idx)};
        dat_dly[0] <= pix_func(lfsr_state);
        for (int k = 1; k < 5; k++) dat_dly[k] <= dat_dly[k-1];
        if (reset_i || sa_clear_o) sa_sig <= '0;
        else if (sa_en_o && px_rdy_i) sa_sig <= misr(sa_sig, dat_dly[4]);
    end

    typedef struct {
        logic [SIG_W-1:0] sig;
        logic             pass;
        logic             timeout;
        int               issued;
        int               latency;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   run_no = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({lfsr_cfg_o, lfsr_cfg_rdy_o, lfsr_cfg_data_o, lfsr_en_o, sa_en_o,
                    sa_clear_o, busy_o, done_o, pass_o, timeout_o, signature_o});
    endfunction

    // Monitor: on each rising done_o, pop the oldest expectation and compare.
    task automatic monitor();
        int   cyc = 0;
        int   clear_cyc = 0;
        int   issued = 0;
        logic done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (sa_clear_o) begin
                issued    = 0;
                clear_cyc = cyc;
            end else if (lfsr_rdy_i) begin
                issued++;
            end
            if (done_o && !done_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done_o=1 required no pending run");
                end else begin
                    e = sb_q.pop_front();
                    run_no++;
                    check("signature", 64'(signature_o), 64'(e.sig));
                    check("pass", 64'(pass_o), 64'(e.pass));
                    check("timeout", 64'(timeout_o), 64'(e.timeout));
                    check("issued_pixels", 64'(issued), 64'(e.issued));
                    if (e.latency >= 0) check("done_latency", 64'(cyc - clear_cyc), 64'(e.latency));
                    $display("run %0d: sig=%06h pass=%0d timeout=%0d issued=%0d",
                             run_no, signature_o, pass_o, timeout_o, issued);
                end
            end
            done_prev = done_o;
        end
    endtask

    // One complete run: push the expectation, pulse start, wait for done.
    task automatic run(input int n, input logic [PX_W-1:0] seed, input int drop,
                       input bit match, input bit poke);
        exp_t             e;
        logic [SIG_W-1:0] gold;
        bit               dropped;
        int               bound;
        dropped   = (drop >= 0) && (drop < n);
        e.sig     = ref_signature(seed, n, drop);
        gold      = match ? e.sig : (e.sig ^ (SIG_W'(1) << $urandom_range(0, SIG_W - 1)));
        e.pass    = (gold == e.sig) && !dropped;
        e.timeout = dropped;
        e.issued  = n;
        e.latency = dropped ? -1 : ((n == 0) ? 2 : n + 8);
        sb_q.push_back(e);
        drop_idx    = drop;
        frame_len_i = CNT_W'(n);
        seed_i      = seed;
        golden_i    = gold;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("clear_strobe", 64'(sa_clear_o), 64'(1));
        check("busy", 64'(busy_o), 64'(1));
        @(negedge clk);
        check("seed_strobe", 64'(lfsr_cfg_rdy_o), 64'(n != 0));
        if (n != 0) check("seed_data", 64'(lfsr_cfg_data_o), 64'(seed));
        if (poke) begin
            repeat (5) @(negedge clk);
            frame_len_i = CNT_W'(3);
            seed_i      = ~seed;
            start_i     = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        bound = n + 200;
        while (!done_o && bound > 0) begin
            @(negedge clk);
            bound--;
        end
        if (!done_o) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got done_o=0 required 1 within %0d cycles", n + 200);
        end
    endtask

    initial begin
        int bound;
        reset_i     = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        frame_len_i = '0;
        seed_i      = '0;
        golden_i    = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 64'(0));
        reset_i = 1'b0;
        @(negedge clk);
        check("idle_outputs", all_outputs(), 64'(0));

        // Nominal frame, then mismatched golden with an ignored mid-run start.
        run(16, PX_W'(24'h00ACE1), -1, 1'b1, 1'b0);
        run(16, PX_W'(24'h00ACE1), -1, 1'b0, 1'b1);
        // Lost pixel: drain watchdog expires.
        run(8, PX_W'($urandom_range(1, 24'hFFFFFF)), 3, 1'b1, 1'b0);
        // Empty frames.
        run(0, PX_W'($urandom_range(1, 24'hFFFFFF)), -1, 1'b1, 1'b0);
        run(0, PX_W'($urandom_range(1, 24'hFFFFFF)), -1, 1'b0, 1'b0);
        // Randomized frames.
        for (int r = 0; r < 8; r++) begin
            run(int'($urandom_range(1, 40)), PX_W'($urandom_range(1, 24'hFFFFFF)), -1,
                bit'($urandom_range(0, 1)), 1'b0);
        end

        // Abort in RUN cycle 4 together with a start request.
        drop_idx    = -1;
        frame_len_i = CNT_W'(16);
        seed_i      = PX_W'(24'h123456);
        golden_i    = '0;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        check("run_enable", 64'(lfsr_en_o), 64'(1));
        repeat (3) @(negedge clk);
        abort_i     = 1'b1;
        start_i     = 1'b1;
        frame_len_i = CNT_W'(5);
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_outputs", all_outputs(), 64'(0));
        @(negedge clk);
        check("abort_stays_idle", all_outputs(), 64'(0));
        repeat (10) @(negedge clk);

        // Reset during DRAIN, then a clean run.
        frame_len_i = CNT_W'(16);
        seed_i      = PX_W'(24'h5A5A5A);
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        bound = 100;
        while (!(sa_en_o && !lfsr_en_o && busy_o) && bound > 0) begin
            @(negedge clk);
            bound--;
        end
        check("reach_drain", 64'(sa_en_o && !lfsr_en_o && busy_o), 64'(1));
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        check("reset_in_drain", all_outputs(), 64'(0));
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        run(16, PX_W'(24'h5A5A5A), -1, 1'b1, 1'b0);

        bound = 200;
        while (sb_q.size() != 0 && bound > 0) begin
            @(negedge clk);
            bound--;
        end
        @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
